// File: rtl/fifo_dcfifo_pkg.sv
// Shared constants, pointer types and Gray-code helpers for the dual-clock byte-to-halfword FIFO.
// Pointer helpers operate on the wider write pointer; read pointers are zero-extended into them.
package fifo_dcfifo_pkg;

  localparam int WR_AW = 8;
  localparam int RD_AW = 7;
  localparam int WPTR_W = WR_AW + 1;
  localparam int RPTR_W = RD_AW + 1;

  typedef logic [WPTR_W-1:0] wptr_t;
  typedef logic [RPTR_W-1:0] rptr_t;

  function automatic wptr_t bin2gray(input wptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic wptr_t gray2bin(input wptr_t g);
    wptr_t b;
    b[WPTR_W-1] = g[WPTR_W-1];
    for (int i = WPTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-stage synchronizer for a Gray-coded pointer entering i_clk's domain.
// Only one bit changes per source update, so the captured word is always a valid old or new pointer.
module fifo_ptr_sync #(
  parameter int W      = 9,
  parameter int SYNC_N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_N; gi++) begin : g_stage
      logic [W-1:0] r_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= i_d;
        end
      end else begin : g_next
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  assign o_q = g_stage[SYNC_N-1].r_q;

endmodule

// File: rtl/fifo_dcfifo.sv
// Dual-clock FIFO: bytes in on wr_clk, packed 16-bit words out on rd_clk, Gray pointers across domains.
// Define FIFO_SHOWAHEAD_EN for show-ahead reads (head word presented whenever rd_empty=0).
module fifo_dcfifo
  import fifo_dcfifo_pkg::*;
#(
  parameter int WR_W     = 8,
  parameter int RD_W     = 16,
  parameter int WR_DEPTH = 256,
  parameter int SYNC_N   = 2
) (
  input  logic            wr_clk,
  input  logic            sys_rst_n,
  input  logic            rd_clk,
  input  logic            wr_req,
  input  logic [WR_W-1:0] wr_data,
  input  logic            rd_req,
  output logic [RD_W-1:0] rd_data,
  output logic            wr_empty,
  output logic            wr_full,
  output logic [WPTR_W-1:0] wr_usedw,
  output logic            rd_empty,
  output logic            rd_full,
  output logic [RPTR_W-1:0] rd_usedw
);

  localparam wptr_t WR_FULL_CNT = wptr_t'(WR_DEPTH);
  localparam rptr_t RD_FULL_CNT = rptr_t'(WR_DEPTH / 2);

  logic [WR_W-1:0] r_mem [WR_DEPTH];

  // ---------------- write domain ----------------
  wptr_t r_wptr;
  wptr_t r_wptr_gray;
  wptr_t r_wr_usedw;
  logic  r_wr_full;
  logic  r_wr_empty;
  wptr_t w_wptr_next;
  wptr_t w_wr_usedw;
  wptr_t w_rsync_bin;
  rptr_t w_rsync_gray;
  logic  w_wr_accept;

  assign w_wr_accept = wr_req & ~r_wr_full;
  assign w_wptr_next = r_wptr + wptr_t'(w_wr_accept);
  assign w_rsync_bin = gray2bin(wptr_t'(w_rsync_gray));
  // Status uses the post-write pointer so a full FIFO never accepts one extra byte.
  assign w_wr_usedw  = w_wptr_next - (w_rsync_bin << 1);

  always_ff @(posedge wr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wptr      <= '0;
      r_wptr_gray <= '0;
      r_wr_usedw  <= '0;
      r_wr_full   <= 1'b0;
      r_wr_empty  <= 1'b1;
    end else begin
      r_wptr      <= w_wptr_next;
      r_wptr_gray <= bin2gray(w_wptr_next);
      r_wr_usedw  <= w_wr_usedw;
      r_wr_full   <= (w_wr_usedw == WR_FULL_CNT);
      r_wr_empty  <= (w_wr_usedw == '0);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wr_accept) r_mem[r_wptr[WR_AW-1:0]] <= wr_data;
  end

  // ---------------- read domain ----------------
  rptr_t           r_rptr;
  rptr_t           r_rptr_gray;
  rptr_t           r_rd_usedw;
  logic            r_rd_empty;
  logic            r_rd_full;
  logic [RD_W-1:0] r_rd_data;
  rptr_t           w_rptr_next;
  rptr_t           w_rd_usedw;
  wptr_t           w_wsync_gray;
  wptr_t           w_wsync_bin;
  logic            w_rd_accept;
  logic            w_rd_load;
  logic [RD_AW-1:0] w_rd_addr;

  assign w_rd_accept = rd_req & ~r_rd_empty;
  assign w_rptr_next = r_rptr + rptr_t'(w_rd_accept);
  assign w_wsync_bin = gray2bin(w_wsync_gray);
  // Only complete byte pairs count as read words; a trailing odd byte is invisible here.
  assign w_rd_usedw  = rptr_t'((w_wsync_bin >> 1) - wptr_t'(w_rptr_next));

`ifdef FIFO_SHOWAHEAD_EN
  assign w_rd_addr = w_rptr_next[RD_AW-1:0];
  assign w_rd_load = (w_rd_usedw != '0);
`else
  assign w_rd_addr = r_rptr[RD_AW-1:0];
  assign w_rd_load = w_rd_accept;
`endif

  always_ff @(posedge rd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rptr      <= '0;
      r_rptr_gray <= '0;
      r_rd_usedw  <= '0;
      r_rd_empty  <= 1'b1;
      r_rd_full   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rptr      <= w_rptr_next;
      r_rptr_gray <= rptr_t'(bin2gray(wptr_t'(w_rptr_next)));
      r_rd_usedw  <= w_rd_usedw;
      r_rd_empty  <= (w_rd_usedw == '0);
      r_rd_full   <= (w_rd_usedw == RD_FULL_CNT);
      if (w_rd_load) r_rd_data <= {r_mem[{w_rd_addr, 1'b1}], r_mem[{w_rd_addr, 1'b0}]};
    end
  end

  // ---------------- pointer crossings ----------------
  fifo_ptr_sync #(.W(WPTR_W), .SYNC_N(SYNC_N)) u_wptr_sync (
    .i_clk   (rd_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (r_wptr_gray),
    .o_q     (w_wsync_gray)
  );

  fifo_ptr_sync #(.W(RPTR_W), .SYNC_N(SYNC_N)) u_rptr_sync (
    .i_clk   (wr_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (r_rptr_gray),
    .o_q     (w_rsync_gray)
  );

  assign rd_data  = r_rd_data;
  assign wr_empty = r_wr_empty;
  assign wr_full  = r_wr_full;
  assign wr_usedw = r_wr_usedw;
  assign rd_empty = r_rd_empty;
  assign rd_full  = r_rd_full;
  assign rd_usedw = r_rd_usedw;

endmodule

// File: tb/tb_fifo_dcfifo.sv
// Scoreboard bench for fifo_dcfifo: writes queue expected words, a read monitor pops and compares.
module tb_fifo_dcfifo;

  logic        wr_clk = 1'b0;
  logic        rd_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_req = 1'b0;
  logic [15:0] rd_data;
  logic        wr_empty, wr_full, rd_empty, rd_full;
  logic [8:0]  wr_usedw;
  logic [7:0]  rd_usedw;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int m_bytes = 0;
  logic m_odd = 1'b0;
  logic [7:0] m_lo = 8'h00;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int n;

  fifo_dcfifo dut (
    .wr_clk    (wr_clk),
    .sys_rst_n (sys_rst_n),
    .rd_clk    (rd_clk),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .wr_empty  (wr_empty),
    .wr_full   (wr_full),
    .wr_usedw  (wr_usedw),
    .rd_empty  (rd_empty),
    .rd_full   (rd_full),
    .rd_usedw  (rd_usedw)
  );

  initial forever #10 wr_clk = ~wr_clk;
  initial begin
    #3;
    forever #20 rd_clk = ~rd_clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One accepted write per call; the model decides acceptance from its own byte count.
  task automatic wr_byte(input logic [7:0] b, input int gap);
    @(negedge wr_clk);
    wr_req  = 1'b1;
    wr_data = b;
    if (m_bytes < 256) begin
      m_bytes++;
      if (m_odd) exp_q.push_back({b, m_lo});
      else       m_lo = b;
      m_odd = ~m_odd;
      $display("wr byte %h accepted", b);
    end else begin
      $display("wr byte %h dropped (full)", b);
    end
    @(negedge wr_clk);
    wr_req = 1'b0;
    repeat (gap) @(negedge wr_clk);
  endtask

  task automatic rd_one();
    @(negedge rd_clk);
    rd_req = 1'b1;
    @(negedge rd_clk);
    rd_req = 1'b0;
  endtask

  // Monitor: an accepted read must present the next queued word 1 rd_clk later.
  always @(posedge rd_clk) begin
    if (sys_rst_n && rd_req && !rd_empty) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("rd_unexpected_word", int'(rd_data), -1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", int'(rd_data), int'(mon_exp));
        pops++;
        m_bytes -= 2;
        $display("rd word %h (expected %h)", rd_data, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    #1 sys_rst_n = 1'b0;
    #20;
    chk("rst_wr_empty", int'(wr_empty), 1);
    chk("rst_rd_empty", int'(rd_empty), 1);
    chk("rst_wr_full",  int'(wr_full),  0);
    chk("rst_rd_full",  int'(rd_full),  0);
    chk("rst_wr_usedw", int'(wr_usedw), 0);
    chk("rst_rd_usedw", int'(rd_usedw), 0);
    chk("rst_rd_data",  int'(rd_data),  0);
    #5 sys_rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);

    // 2: fill with 0..255, one byte every 4 wr_clk
    for (int i = 0; i < 256; i++) wr_byte(i[7:0], 2);
    chk("fill_wr_full",  int'(wr_full),  1);
    chk("fill_wr_usedw", int'(wr_usedw), 256);
    chk("fill_wr_empty", int'(wr_empty), 0);
    n = 0;
    while (rd_usedw != 8'd128 && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    chk("fill_rd_usedw", int'(rd_usedw), 128);
    chk("fill_rd_full",  int'(rd_full),  1);
    chk("fill_rd_empty", int'(rd_empty), 0);

    // 5a: writes while full are dropped
    for (int i = 0; i < 4; i++) wr_byte(8'hEE, 0);
    chk("ovf_wr_usedw", int'(wr_usedw), 256);
    chk("ovf_wr_full",  int'(wr_full),  1);

    // 3: drain continuously
    @(negedge rd_clk);
    rd_req = 1'b1;
    n = 0;
    while (pops < 128 && n < 300) begin
      @(negedge rd_clk);
      n++;
    end
    rd_req = 1'b0;
    chk("drain_count",    pops,             128);
    chk("drain_rd_empty", int'(rd_empty),   1);
    chk("drain_rd_usedw", int'(rd_usedw),   0);
    chk("drain_rd_full",  int'(rd_full),    0);
    n = 0;
    while (!wr_empty && n < 10) begin
      @(negedge wr_clk);
      n++;
    end
    chk("drain_wr_empty", int'(wr_empty), 1);
    chk("drain_wr_usedw", int'(wr_usedw), 0);

    // 5b: reads while empty leave rd_data alone
    @(negedge rd_clk);
    rd_req = 1'b1;
    repeat (3) @(negedge rd_clk);
    rd_req = 1'b0;
    chk("udf_rd_data",  int'(rd_data),  16'hFFFE);
    chk("udf_rd_usedw", int'(rd_usedw), 0);
    chk("udf_rd_empty", int'(rd_empty), 1);

    // 4: odd byte stays unreadable
    wr_byte(8'hA1, 0);
    wr_byte(8'hB2, 0);
    wr_byte(8'hC3, 0);
    n = 0;
    while (rd_usedw != 8'd1 && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    chk("odd_rd_usedw", int'(rd_usedw), 1);
    rd_one();
    n = 0;
    while (wr_usedw != 9'd1 && n < 15) begin
      @(negedge wr_clk);
      n++;
    end
    chk("odd_wr_usedw", int'(wr_usedw), 1);
    repeat (4) @(negedge rd_clk);
    chk("odd_rd_empty",  int'(rd_empty), 1);
    chk("odd_rd_usedw0", int'(rd_usedw), 0);
    chk("odd_pops",      pops,           129);

    // 6: mid-operation reset while about half full
    for (int i = 0; i < 100; i++) wr_byte(8'(i + 16), 0);
    n = 0;
    while (rd_usedw != 8'd50 && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    chk("mid_rd_usedw", int'(rd_usedw), 50);
    chk("mid_wr_usedw", int'(wr_usedw), 101);
    @(negedge wr_clk);
    #3 sys_rst_n = 1'b0;
    #2;
    chk("mrst_wr_empty", int'(wr_empty), 1);
    chk("mrst_rd_empty", int'(rd_empty), 1);
    chk("mrst_wr_full",  int'(wr_full),  0);
    chk("mrst_rd_full",  int'(rd_full),  0);
    chk("mrst_wr_usedw", int'(wr_usedw), 0);
    chk("mrst_rd_usedw", int'(rd_usedw), 0);
    chk("mrst_rd_data",  int'(rd_data),  0);
    exp_q.delete();
    m_bytes = 0;
    m_odd = 1'b0;
    #10 sys_rst_n = 1'b1;
    repeat (4) @(negedge wr_clk);
    wr_byte(8'h5A, 0);
    wr_byte(8'hC7, 0);
    n = 0;
    while (rd_usedw != 8'd1 && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    chk("post_rd_usedw", int'(rd_usedw), 1);
    rd_one();
    repeat (2) @(negedge rd_clk);
    chk("post_rd_data", int'(rd_data), 16'hC75A);
    chk("post_pops",    pops,          130);
    chk("post_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
